// File: rtl/register_file_sb.sv
// Multi-entry register file with two read ports, optional write bypass
// and a per-entry busy scoreboard for long-latency results.
module register_file_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             w_en,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             r_enA,
    input  logic             r_enB,
    input  logic [AW-1:0]    r_addrA,
    input  logic [AW-1:0]    r_addrB,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    input  logic             busy_set,
    input  logic [AW-1:0]    busy_addr,
    output logic             busyA,
    output logic             busyB,
    output logic [AW:0]      busy_count
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_busy_count;

    logic             w_we;
    logic             w_bs;
    logic             w_hitA;
    logic             w_hitB;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;

    // An entry is real storage only if in range and not the hardwired zero.
    function automatic logic f_real(input logic [AW-1:0] a);
        logic w_in_range;
        logic w_is_zero;
        w_in_range = ({1'b0, a} < LP_DEPTH);
        w_is_zero  = (ZERO_REG != 0) && (a == '0);
        return w_in_range && !w_is_zero;
    endfunction

    assign w_we   = w_en && f_real(w_addr);
    assign w_bs   = busy_set && f_real(busy_addr);
    assign w_hitA = (BYPASS != 0) && w_we && (w_addr == r_addrA);
    assign w_hitB = (BYPASS != 0) && w_we && (w_addr == r_addrB);

    // Next busy vector: a write clears, a reissue sets and wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we) begin
            w_busy_nxt[w_addr] = 1'b0;
        end
        if (w_bs) begin
            w_busy_nxt[busy_addr] = 1'b1;
        end
    end

    // Population count of the next busy vector.
    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
        end
    end

    // Data storage.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[w_addr] <= w_data;
        end
    end

    // Busy bits and their registered count move together.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_cnt_nxt;
        end
    end

    // Read port A with optional forwarding of the in-flight write.
    always_comb begin
        outA  = '0;
        busyA = 1'b0;
        if (r_enA && f_real(r_addrA)) begin
            if (w_hitA) begin
                outA = w_data;
            end else begin
                outA  = r_mem[r_addrA];
                busyA = r_busy[r_addrA];
            end
        end
    end

    // Read port B with optional forwarding of the in-flight write.
    always_comb begin
        outB  = '0;
        busyB = 1'b0;
        if (r_enB && f_real(r_addrB)) begin
            if (w_hitB) begin
                outB = w_data;
            end else begin
                outB  = r_mem[r_addrB];
                busyB = r_busy[r_addrB];
            end
        end
    end

    assign busy_count = r_busy_count;

endmodule
